// File: rtl/esc_enc_pkg.sv
// Shared types for the encoder alignment sequencer: FSM states, fault codes,
// and the width of the quadrature position coming from the decoder.
package esc_enc_pkg;

  localparam int unsigned POS_W = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ZERO,
    S_VERIFY,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_DRIFT   = 3'd1;
  localparam logic [2:0] FC_ILLEGAL = 3'd2;
  localparam logic [2:0] FC_ZACK    = 3'd3;

endpackage

// File: rtl/sat_updown_cnt.sv
// Signed up/down counter that saturates at the two's-complement limits.
// Exposes the next-state value so callers can react in the same cycle.
module sat_updown_cnt #(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                up_i,
  output logic signed [W-1:0] cnt_d_o,
  output logic signed [W-1:0] cnt_q_o
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i) begin
      if (up_i) begin
        if (cnt_q != MAXV) cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q != MINV) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_d_o = cnt_d;
  assign cnt_q_o = cnt_q;

endmodule

// File: rtl/enc_align_seq.sv
// Rotor/encoder alignment sequencer: hold the align vector, zero the decoder,
// then watch for drift and illegal transitions before declaring done.
module enc_align_seq
  import esc_enc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 50000000,
  parameter int unsigned ZERO_HOLD     = 2,
  parameter int unsigned VERIFY_CYCLES = 25000000,
  parameter int unsigned DRIFT_TOL     = 4,
  parameter int unsigned ILLEGAL_MAX   = 8,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step_pulse,
  input  logic             dir,
  input  logic             illegal,
  input  logic [POS_W-1:0] pos14,
  output logic             align_en,
  output logic             zero_req,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [15:0]      drift
);

  localparam int unsigned IW = $clog2(ILLEGAL_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ZERO_LAST   = CNT_W'(ZERO_HOLD - 1);
  localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_CYCLES - 1);
  localparam logic [IW-1:0]    ILL_LAST    = IW'(ILLEGAL_MAX);
  localparam logic signed [15:0] DTOL      = 16'(DRIFT_TOL);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IW-1:0]    ill_q, ill_d;
  logic [2:0]       fc_q, fc_d;
  logic             align_q, zero_q, done_q, fault_q;

  logic             act, idle_like, drift_clr, drift_en, drift_over;
  logic signed [15:0] drift_nx, drift_cur;

  assign act       = (state_q == S_SETTLE) || (state_q == S_ZERO) || (state_q == S_VERIFY);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT);

  // Drift restarts on (re)start, abort, and on entry to VERIFY; it only counts in VERIFY.
  assign drift_clr = abort || (idle_like && start) ||
                     ((state_q == S_ZERO) && (timer_q == ZERO_LAST));
  assign drift_en  = (state_q == S_VERIFY) && step_pulse;

  sat_updown_cnt #(.W(16)) u_drift (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (drift_clr),
    .en_i    (drift_en),
    .up_i    (dir),
    .cnt_d_o (drift_nx),
    .cnt_q_o (drift_cur)
  );

  assign drift_over = (drift_nx > DTOL) || (drift_nx < -DTOL);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ill_d   = ill_q;
    fc_d    = fc_q;
    if (act && illegal && (ill_q != ILL_LAST)) ill_d = ill_q + IW'(1);

    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d = S_SETTLE;
          timer_d = '0;
          ill_d   = '0;
          fc_d    = FC_NONE;
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = S_ZERO;
          timer_d = '0;
        end else timer_d = timer_q + CNT_W'(1);
      end
      S_ZERO: begin
        if (timer_q == ZERO_LAST) begin
          state_d = S_VERIFY;
          timer_d = '0;
        end else timer_d = timer_q + CNT_W'(1);
      end
      S_VERIFY: begin
        if (timer_q == VERIFY_LAST) state_d = S_DONE;
        else timer_d = timer_q + CNT_W'(1);
        // Later assignments win: zero-ack outranks drift, both outrank DONE.
        if (drift_over) begin
          state_d = S_FAULT;
          fc_d    = FC_DRIFT;
        end
        if ((timer_q == '0) && (pos14 != '0)) begin
          state_d = S_FAULT;
          fc_d    = FC_ZACK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (act && (ill_d == ILL_LAST)) begin
      state_d = S_FAULT;
      fc_d    = FC_ILLEGAL;
    end

    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
      ill_d   = '0;
      fc_d    = FC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      ill_q   <= '0;
      fc_q    <= FC_NONE;
      align_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ill_q   <= ill_d;
      fc_q    <= fc_d;
      align_q <= (state_d == S_SETTLE) || (state_d == S_ZERO) || (state_d == S_VERIFY);
      zero_q  <= (state_d == S_ZERO);
      done_q  <= (state_d == S_DONE);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign align_en   = align_q;
  assign busy       = align_q;
  assign zero_req   = zero_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fc_q;
  assign drift      = drift_cur;

endmodule

// File: tb/tb_enc_align_seq.sv
// Directed bench for enc_align_seq with a small decoder model and a
// scoreboard of expected end-of-sequence outcomes.
module tb_enc_align_seq;

  localparam int SC = 10, ZH = 2, VC = 20, DT = 2, IM = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, step_pulse, dir, illegal;
  logic [13:0] pos14;
  logic        align_en, zero_req, busy, done, fault;
  logic [2:0]  fault_code;
  logic [15:0] drift;

  logic        zack_en, load_pos;
  logic [13:0] load_val;
  int          n_cmp = 0, n_err = 0, cyc = 0, base = 0;

  typedef struct {
    string       tag;
    logic        done;
    logic        fault;
    logic [2:0]  code;
    logic [15:0] drift;
    int          rel;
  } res_t;
  res_t sb[$];

  enc_align_seq #(
    .SETTLE_CYCLES(SC), .ZERO_HOLD(ZH), .VERIFY_CYCLES(VC),
    .DRIFT_TOL(DT), .ILLEGAL_MAX(IM), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .step_pulse(step_pulse), .dir(dir), .illegal(illegal), .pos14(pos14),
    .align_en(align_en), .zero_req(zero_req), .busy(busy), .done(done),
    .fault(fault), .fault_code(fault_code), .drift(drift)
  );

  always #5 clk = ~clk;

  // Decoder model: position is loaded by the bench, cleared on zero_req if acking.
  always @(posedge clk) begin
    if (load_pos) pos14 <= load_val;
    else if (zero_req && zack_en) pos14 <= '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_rel(input int r);
    while (cyc - base < r) tick();
  endtask

  task automatic load(input logic [13:0] v);
    load_val = v; load_pos = 1'b1; tick(); load_pos = 1'b0;
  endtask

  task automatic go();
    base = cyc; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push(input string tag, input logic d, input logic f,
                      input logic [2:0] c, input logic [15:0] dr, input int rel);
    res_t e;
    e.tag = tag; e.done = d; e.fault = f; e.code = c; e.drift = dr; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic wait_end();
    res_t e;
    int   n = 0;
    while (!(done || fault) && n < 200) begin tick(); n++; end
    e = sb.pop_front();
    chk({e.tag, "_timeout"}, 32'(n < 200), 32'd1);
    chk({e.tag, "_cycle"},   32'(cyc - base), 32'(e.rel));
    chk({e.tag, "_done"},    32'(done), 32'(e.done));
    chk({e.tag, "_fault"},   32'(fault), 32'(e.fault));
    chk({e.tag, "_code"},    32'(fault_code), 32'(e.code));
    chk({e.tag, "_drift"},   32'(drift), 32'(e.drift));
    chk({e.tag, "_align"},   32'(align_en), 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_outs"}, {25'd0, align_en, zero_req, busy, done, fault, 2'd0}, 32'd0);
    chk({tag, "_code"}, 32'(fault_code), 32'd0);
    chk({tag, "_drift"}, 32'(drift), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_pulse = 1'b0; dir = 1'b0;
    illegal = 1'b0; zack_en = 1'b1; load_pos = 1'b0; load_val = '0;
    tick(); tick();
    all_zero("reset");
    rst = 1'b0;
    tick();

    // 1. Nominal
    load(14'd100);
    push("nominal", 1'b1, 1'b0, 3'd0, 16'd0, 33);
    go();
    chk("nom_align_c1", 32'(align_en), 32'd1);
    chk("nom_busy_c1", 32'(busy), 32'd1);
    to_rel(10); chk("nom_zreq_c10", 32'(zero_req), 32'd0);
    to_rel(11); chk("nom_zreq_c11", 32'(zero_req), 32'd1);
    to_rel(12); chk("nom_zreq_c12", 32'(zero_req), 32'd1);
    to_rel(13); chk("nom_zreq_c13", 32'(zero_req), 32'd0);
    to_rel(32); chk("nom_align_c32", 32'(align_en), 32'd1);
    chk("nom_done_c32", 32'(done), 32'd0);
    wait_end();
    tick(); tick();
    chk("nom_done_sticky", 32'(done), 32'd1);

    // 2. Motion during SETTLE is ignored
    load(14'd100);
    push("settle_motion", 1'b1, 1'b0, 3'd0, 16'd0, 33);
    go();
    step_pulse = 1'b1; dir = 1'b1;
    to_rel(11);
    step_pulse = 1'b0;
    wait_end();

    // 3a. Drift over tolerance
    load(14'd100);
    push("drift_cw", 1'b0, 1'b1, 3'd1, 16'd3, 18);
    go();
    to_rel(15);
    step_pulse = 1'b1; dir = 1'b1;
    to_rel(18);
    step_pulse = 1'b0;
    wait_end();

    // 3b. Drift within tolerance
    load(14'd100);
    push("drift_acw", 1'b1, 1'b0, 3'd0, 16'hFFFE, 33);
    go();
    to_rel(15);
    step_pulse = 1'b1; dir = 1'b0;
    to_rel(17);
    step_pulse = 1'b0;
    wait_end();

    // 4a. Illegal strobes in SETTLE
    load(14'd100);
    push("illegal_settle", 1'b0, 1'b1, 3'd2, 16'd0, 5);
    go();
    to_rel(2);
    illegal = 1'b1;
    to_rel(5);
    illegal = 1'b0;
    wait_end();

    // 4b. Illegal and drift in the same cycle: illegal wins
    load(14'd100);
    push("illegal_vs_drift", 1'b0, 1'b1, 3'd2, 16'd3, 18);
    go();
    to_rel(2); illegal = 1'b1;
    to_rel(4); illegal = 1'b0;
    to_rel(15); step_pulse = 1'b1; dir = 1'b1;
    to_rel(17); illegal = 1'b1;
    to_rel(18); illegal = 1'b0; step_pulse = 1'b0;
    wait_end();

    // 5. Zero request not acknowledged
    zack_en = 1'b0;
    load(14'd100);
    push("zero_nack", 1'b0, 1'b1, 3'd3, 16'd0, 14);
    go();
    wait_end();
    zack_en = 1'b1;

    // 6a. Restart from FAULT clears it and repeats nominal
    load(14'd100);
    push("restart", 1'b1, 1'b0, 3'd0, 16'd0, 33);
    go();
    chk("restart_fault_clr", 32'(fault), 32'd0);
    chk("restart_code_clr", 32'(fault_code), 32'd0);
    wait_end();

    // 6b. abort with start mid-VERIFY
    load(14'd100);
    go();
    to_rel(15); step_pulse = 1'b1; dir = 1'b1;
    to_rel(16); step_pulse = 1'b0;
    chk("abort_pre_drift", 32'(drift), 32'd1);
    to_rel(20); abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    all_zero("abort");

    // 6c. rst mid-ZERO
    load(14'd100);
    go();
    to_rel(11);
    chk("rst_pre_zreq", 32'(zero_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_zero("rst_mid_zero");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
